hazard_md_unit: RTL and testbench

- Second-generation hazard unit for the 5-stage pipeline. It merges operand forwarding, load-use interlock and a multi-cycle mult/div sequencer into one block.
- It sits beside the FD/DX/XM/MW latches. It drives the forwarding mux selects, the stall/bubble controls and the multdiv handshake.
- Adds new behaviour: a stateful mult/div FSM with a busy counter and timeout, and parametrised register-index width.

---
 rtl/hazard_md_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_hazard_md_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_md_unit.sv
// -----------------------------------------------------------------------------
// hazard_md_unit
//
// Hazard unit for the 5-stage pipeline. It combines three functions:
//   * operand forwarding for the ALU A/B inputs and the dmem data input,
//   * the load-use interlock (one stall/bubble cycle),
//   * the mult/div sequencer: IDLE -> BUSY -> DONE, with a busy counter
//     that aborts the operation after MD_TIMEOUT cycles.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   fd/dx/xm/mw_insn    instructions currently held in each pipeline latch
//   md_ready            multdiv result valid (only looked at while BUSY)
//   fwd_a_sel/fwd_b_sel ALU operand select: 00 DX operand, 01 XM O, 10 writeback
//   fwd_dmem_sel        1 = writeback data drives dmem data in, 0 = XM B
//   stall_fd            hold PC and FD latch
//   bubble_dx           load a nop into DX
//   hold_dx             hold the DX latch
//   bubble_xm           load a nop into XM
//   md_start            one-cycle start pulse to the multdiv unit
//   md_is_div           latched operation type (1 = div)
//   md_dest             latched destination register of the mult/div
//   md_wb               one-cycle strobe: multdiv result advances into XM
//   md_error            sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module hazard_md_unit #(
    parameter int unsigned REG_BITS    = 5,
    parameter int unsigned MD_TIMEOUT  = 64,
    parameter int unsigned LOAD_USE_EN = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         fd_insn,
    input  logic [31:0]         dx_insn,
    input  logic [31:0]         xm_insn,
    input  logic [31:0]         mw_insn,
    input  logic                md_ready,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic                fwd_dmem_sel,
    output logic                stall_fd,
    output logic                bubble_dx,
    output logic                hold_dx,
    output logic                bubble_xm,
    output logic                md_start,
    output logic                md_is_div,
    output logic [REG_BITS-1:0] md_dest,
    output logic                md_wb,
    output logic                md_error
);

    typedef logic [REG_BITS-1:0] reg_t;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [15:0] CNT_LAST = 16'(MD_TIMEOUT - 1);
    localparam bit          LU_ON    = (LOAD_USE_EN != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // ---------------------------------------------------------------- decode
    // Register written by an instruction; 0 means "writes nothing".
    function automatic reg_t dest_of(input logic [31:0] insn);
        reg_t d;
        case (insn[31:27])
            OP_RTYPE, OP_ADDI, OP_LW: d = reg_t'(insn[26:22]);
            OP_JAL:                   d = reg_t'(5'd31);
            OP_SETX:                  d = reg_t'(5'd30);
            default:                  d = '0;
        endcase
        return d;
    endfunction

    // ALU A source; 0 means "no source" (r0 is never forwarded anyway).
    function automatic reg_t src_a_of(input logic [31:0] insn);
        reg_t s;
        case (insn[31:27])
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW: s = reg_t'(insn[21:17]);
            OP_BNE, OP_BLT, OP_JR:           s = reg_t'(insn[26:22]);
            OP_BEX:                          s = reg_t'(5'd30);
            default:                         s = '0;
        endcase
        return s;
    endfunction

    // ALU B source. The sw data operand is not an ALU source; it has its own
    // dmem forwarding path.
    function automatic reg_t src_b_of(input logic [31:0] insn);
        reg_t s;
        case (insn[31:27])
            OP_RTYPE:       s = reg_t'(insn[16:12]);
            OP_BNE, OP_BLT: s = reg_t'(insn[21:17]);
            default:        s = '0;
        endcase
        return s;
    endfunction

    // XM wins over MW because it holds the younger result. A load in XM has
    // no data yet, so it is skipped and the load-use interlock covers it.
    function automatic logic [1:0] fwd_select(input reg_t src, input reg_t xm_d,
                                              input reg_t mw_d, input logic xm_lw);
        logic [1:0] sel;
        if (src != '0 && src == xm_d && !xm_lw)
            sel = 2'b01;
        else if (src != '0 && src == mw_d)
            sel = 2'b10;
        else
            sel = 2'b00;
        return sel;
    endfunction

    reg_t xm_dest, mw_dest, dx_dest;
    reg_t dx_src_a, dx_src_b, fd_src_a, fd_src_b;
    logic xm_is_lw, xm_is_sw, dx_is_lw, dx_is_md;

    assign xm_dest  = dest_of(xm_insn);
    assign mw_dest  = dest_of(mw_insn);
    assign dx_dest  = dest_of(dx_insn);
    assign dx_src_a = src_a_of(dx_insn);
    assign dx_src_b = src_b_of(dx_insn);
    assign fd_src_a = src_a_of(fd_insn);
    assign fd_src_b = src_b_of(fd_insn);
    assign xm_is_lw = (xm_insn[31:27] == OP_LW);
    assign xm_is_sw = (xm_insn[31:27] == OP_SW);
    assign dx_is_lw = (dx_insn[31:27] == OP_LW);
    assign dx_is_md = (dx_insn[31:27] == OP_RTYPE) &&
                      (dx_insn[6:2] == ALU_MUL || dx_insn[6:2] == ALU_DIV);

    // ------------------------------------------------------------ forwarding
    assign fwd_a_sel    = fwd_select(dx_src_a, xm_dest, mw_dest, xm_is_lw);
    assign fwd_b_sel    = fwd_select(dx_src_b, xm_dest, mw_dest, xm_is_lw);
    assign fwd_dmem_sel = xm_is_sw && (mw_dest != '0) &&
                          (reg_t'(xm_insn[26:22]) == mw_dest);

    // -------------------------------------------------------------- load-use
    // dx_dest is nonzero here, so a "no source" value of 0 can never match.
    logic load_use;
    assign load_use = LU_ON && dx_is_lw && (dx_dest != '0) &&
                      (dx_dest == fd_src_a || dx_dest == fd_src_b);

    // ------------------------------------------------------- mult/div FSM
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    reg_t        md_dest_q, md_dest_d;
    logic        md_is_div_q, md_is_div_d;
    logic        md_error_q, md_error_d;
    logic        start_raw, wb_raw, busy;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_dest_d   = md_dest_q;
        md_is_div_d = md_is_div_q;
        md_error_d  = md_error_q;
        start_raw   = 1'b0;
        wb_raw      = 1'b0;
        busy        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dx_is_md) begin
                    start_raw   = 1'b1;
                    md_dest_d   = reg_t'(dx_insn[26:22]);
                    md_is_div_d = (dx_insn[6:2] == ALU_DIV);
                    cnt_d       = '0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 16'd1;
                // A result arriving on the last allowed cycle still counts.
                if (md_ready) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_IDLE;
                    md_error_d = 1'b1;
                end
            end
            S_DONE: begin
                // The instruction leaves DX this cycle, so returning to IDLE
                // never restarts it.
                wb_raw  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            md_dest_q   <= '0;
            md_is_div_q <= 1'b0;
            md_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_dest_q   <= md_dest_d;
            md_is_div_q <= md_is_div_d;
            md_error_q  <= md_error_d;
        end
    end

    // ----------------------------------------------------------- outputs
    // Control strobes are masked by reset directly so they drop the moment
    // reset rises, not at the next clock edge.
    assign stall_fd  = !reset && (load_use || busy);
    assign bubble_dx = !reset && load_use && !busy;
    assign hold_dx   = !reset && busy;
    assign bubble_xm = !reset && busy;
    assign md_start  = !reset && start_raw;
    assign md_wb     = !reset && wb_raw;
    assign md_is_div = md_is_div_q;
    assign md_dest   = md_dest_q;
    assign md_error  = md_error_q;

endmodule

// File: tb/tb_hazard_md_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_md_unit
//
// Two instances share all inputs:
//   u_dut  : defaults (MD_TIMEOUT=64, load-use interlock on)
//   u_dut2 : MD_TIMEOUT=8, load-use interlock off
// Combinational behaviour is checked from a vector table through an
// expected-value queue; the multi-cycle sequencer cases are hand-written.
// Inputs change 1 ns after the rising edge, outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_md_unit;

    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [31:0] NOP    = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_insn, dx_insn, xm_insn, mw_insn;
    logic        md_ready;

    logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel2, fwd_b_sel2;
    logic       fwd_dmem_sel, fwd_dmem_sel2;
    logic       stall_fd, bubble_dx, hold_dx, bubble_xm, md_start, md_is_div, md_wb, md_error;
    logic       stall_fd2, bubble_dx2, hold_dx2, bubble_xm2, md_start2, md_is_div2, md_wb2, md_error2;
    logic [4:0] md_dest, md_dest2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hazard_md_unit u_dut (
        .clock(clock), .reset(reset),
        .fd_insn(fd_insn), .dx_insn(dx_insn), .xm_insn(xm_insn), .mw_insn(mw_insn),
        .md_ready(md_ready),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_dmem_sel(fwd_dmem_sel),
        .stall_fd(stall_fd), .bubble_dx(bubble_dx), .hold_dx(hold_dx), .bubble_xm(bubble_xm),
        .md_start(md_start), .md_is_div(md_is_div), .md_dest(md_dest),
        .md_wb(md_wb), .md_error(md_error)
    );

    hazard_md_unit #(.REG_BITS(5), .MD_TIMEOUT(8), .LOAD_USE_EN(0)) u_dut2 (
        .clock(clock), .reset(reset),
        .fd_insn(fd_insn), .dx_insn(dx_insn), .xm_insn(xm_insn), .mw_insn(mw_insn),
        .md_ready(md_ready),
        .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2), .fwd_dmem_sel(fwd_dmem_sel2),
        .stall_fd(stall_fd2), .bubble_dx(bubble_dx2), .hold_dx(hold_dx2), .bubble_xm(bubble_xm2),
        .md_start(md_start2), .md_is_div(md_is_div2), .md_dest(md_dest2),
        .md_wb(md_wb2), .md_error(md_error2)
    );

    // ------------------------------------------------------------- helpers
    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] aluop);
        return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs);
        return {op, rd, rs, 17'd0};
    endfunction

    function automatic logic [31:0] jtype(input logic [4:0] op);
        return {op, 27'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // ------------------------------------------------------- vector table
    typedef struct {
        logic [31:0] fd, dx, xm, mw;
        logic [1:0]  a, b;
        logic        dmem, stall, bubble;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    vec_t exp_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   hold_cnt, wb_cnt, start_cnt;
        logic [31:0] mul7, div9;
        mul7 = rtype(5'd7, 5'd1, 5'd2, 5'b00110);
        div9 = rtype(5'd9, 5'd1, 5'd2, 5'b00111);

        //            fd                         dx                         xm                          mw                         a      b      dm    st    bu
        vecs[0]  = '{NOP,                      rtype(5,3,3,0),            rtype(3,1,2,0),             itype(OP_ADDI,3,1),        2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{NOP,                      rtype(5,3,3,0),            NOP,                        itype(OP_ADDI,3,1),        2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{NOP,                      rtype(5,0,0,0),            rtype(0,1,2,0),             itype(OP_ADDI,0,1),        2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{NOP,                      rtype(5,3,2,0),            itype(OP_LW,3,1),           itype(OP_ADDI,3,1),        2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{NOP,                      rtype(5,3,2,0),            rtype(3,1,1,0),             itype(OP_ADDI,2,1),        2'b01, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{NOP,                      itype(OP_BNE,4,6),         itype(OP_ADDI,4,1),         itype(OP_ADDI,6,1),        2'b01, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{NOP,                      jtype(OP_BEX),             NOP,                        jtype(OP_SETX),            2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{NOP,                      itype(OP_JR,31,0),         jtype(OP_JAL),              NOP,                       2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{NOP,                      NOP,                       itype(OP_SW,4,2),           itype(OP_LW,4,1),          2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{NOP,                      NOP,                       itype(OP_SW,0,2),           itype(OP_LW,0,1),          2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{NOP,                      NOP,                       itype(OP_SW,4,2),           rtype(5,1,2,0),            2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{rtype(6,4,2,0),           itype(OP_LW,4,2),          NOP,                        NOP,                       2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{itype(OP_SW,4,2),         itype(OP_LW,4,2),          NOP,                        NOP,                       2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{itype(OP_SW,7,4),         itype(OP_LW,4,2),          NOP,                        NOP,                       2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{rtype(6,0,0,0),           itype(OP_LW,0,2),          NOP,                        NOP,                       2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{itype(OP_BNE,4,1),        itype(OP_LW,4,2),          NOP,                        NOP,                       2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{rtype(6,1,4,0),           itype(OP_LW,4,2),          NOP,                        NOP,                       2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{NOP,                      itype(OP_SW,3,3),          rtype(3,1,2,0),             NOP,                       2'b01, 2'b00, 1'b0, 1'b0, 1'b0};

        // ------------------------------------------------- reset state
        reset = 1'b1; md_ready = 1'b0;
        fd_insn = NOP; dx_insn = mul7; xm_insn = NOP; mw_insn = NOP;
        #2;
        check("rst md_start",  32'(md_start), 0);
        check("rst hold_dx",   32'(hold_dx), 0);
        check("rst stall_fd",  32'(stall_fd), 0);
        check("rst bubble_xm", 32'(bubble_xm), 0);
        check("rst md_dest",   32'(md_dest), 0);
        check("rst md_is_div", 32'(md_is_div), 0);
        check("rst md_error",  32'(md_error), 0);
        check("rst md_wb",     32'(md_wb), 0);
        dx_insn = NOP;
        tick();
        reset = 1'b0;

        // ------------------------------------------------- vector table
        for (int i = 0; i < NV; i++) begin
            tick();
            fd_insn = vecs[i].fd; dx_insn = vecs[i].dx;
            xm_insn = vecs[i].xm; mw_insn = vecs[i].mw;
            exp_q.push_back(vecs[i]);
            sample();
            e = exp_q.pop_front();
            check($sformatf("v%0d fwd_a", i),  32'(fwd_a_sel), 32'(e.a));
            check($sformatf("v%0d fwd_b", i),  32'(fwd_b_sel), 32'(e.b));
            check($sformatf("v%0d dmem", i),   32'(fwd_dmem_sel), 32'(e.dmem));
            check($sformatf("v%0d stall", i),  32'(stall_fd), 32'(e.stall));
            check($sformatf("v%0d bubble", i), 32'(bubble_dx), 32'(e.bubble));
            check($sformatf("v%0d fwd_a2", i), 32'(fwd_a_sel2), 32'(e.a));
            check($sformatf("v%0d nolu2", i),  32'({stall_fd2, bubble_dx2}), 0);
        end

        // ------------------------------------------------- load-use sequences
        tick();
        fd_insn = rtype(6,4,2,0); dx_insn = itype(OP_LW,4,2); xm_insn = NOP; mw_insn = NOP;
        sample();
        check("lu stall c0",  32'(stall_fd), 1);
        check("lu bubble c0", 32'(bubble_dx), 1);
        tick();
        dx_insn = NOP; xm_insn = itype(OP_LW,4,2);
        sample();
        check("lu stall c1",  32'(stall_fd), 0);
        check("lu bubble c1", 32'(bubble_dx), 0);

        tick();
        fd_insn = itype(OP_SW,4,2); dx_insn = itype(OP_LW,4,2); xm_insn = NOP; mw_insn = NOP;
        sample();
        check("sw nostall", 32'(stall_fd), 0);
        tick();
        fd_insn = NOP; dx_insn = itype(OP_SW,4,2); xm_insn = itype(OP_LW,4,2);
        sample();
        check("sw dmem c1", 32'(fwd_dmem_sel), 0);
        check("sw fwd_a c1", 32'(fwd_a_sel), 0);
        tick();
        dx_insn = NOP; xm_insn = itype(OP_SW,4,2); mw_insn = itype(OP_LW,4,2);
        sample();
        check("sw dmem c2", 32'(fwd_dmem_sel), 1);

        // ------------------------------------------------- mul, ready after 16 BUSY cycles
        tick();
        fd_insn = NOP; dx_insn = mul7; xm_insn = NOP; mw_insn = NOP;
        sample();
        check("mul md_start", 32'(md_start), 1);
        check("mul idle hold", 32'(hold_dx), 0);
        hold_cnt = 0; wb_cnt = 0; start_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            md_ready = (i == 15);
            sample();
            if (hold_dx && stall_fd && bubble_xm) hold_cnt++;
            if (md_wb) wb_cnt++;
            if (md_start) start_cnt++;
            if (i == 0) begin
                check("mul md_dest", 32'(md_dest), 7);
                check("mul md_is_div", 32'(md_is_div), 0);
                check("mul busy bubble_dx", 32'(bubble_dx), 0);
            end
        end
        check("mul busy cycles", hold_cnt, 16);
        check("mul wb during busy", wb_cnt, 0);
        check("mul start during busy", start_cnt, 0);
        tick();
        md_ready = 1'b0;
        sample();
        check("mul done md_wb", 32'(md_wb), 1);
        check("mul done hold", 32'(hold_dx), 0);
        check("mul done stall", 32'(stall_fd), 0);
        tick();
        dx_insn = NOP;
        sample();
        check("mul after md_wb", 32'(md_wb), 0);
        check("mul after start", 32'(md_start), 0);
        check("mul after hold", 32'(hold_dx), 0);
        check("mul md_error", 32'(md_error), 0);

        // ------------------------------------------------- reset, then ready on timeout cycle (u_dut2)
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sample();
        check("rst2 md_error2", 32'(md_error2), 0);
        tick();
        dx_insn = mul7;
        sample();
        check("coin md_start2", 32'(md_start2), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            md_ready = (i == 7);
            sample();
        end
        tick();
        md_ready = 1'b0;
        sample();
        check("coin md_wb2", 32'(md_wb2), 1);
        check("coin md_error2", 32'(md_error2), 0);
        tick();
        dx_insn = NOP;
        sample();
        check("coin after md_error2", 32'(md_error2), 0);
        check("coin after md_wb2", 32'(md_wb2), 0);

        // ------------------------------------------------- div timeout (u_dut2)
        tick();
        dx_insn = div9;
        sample();
        check("to md_start2", 32'(md_start2), 1);
        hold_cnt = 0; wb_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            sample();
            if (hold_dx2) hold_cnt++;
            if (md_wb2) wb_cnt++;
            if (i == 0) begin
                check("to md_is_div2", 32'(md_is_div2), 1);
                check("to md_dest2", 32'(md_dest2), 9);
            end
        end
        tick();
        dx_insn = NOP;
        sample();
        check("to busy cycles", hold_cnt, 8);
        check("to hold2 released", 32'(hold_dx2), 0);
        check("to md_error2", 32'(md_error2), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            sample();
            if (md_wb2) wb_cnt++;
        end
        check("to md_error2 sticky", 32'(md_error2), 1);
        check("to no md_wb2", wb_cnt, 0);
        check("to u_dut md_error", 32'(md_error), 0);

        // ------------------------------------------------- reset mid-BUSY (u_dut)
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        dx_insn = mul7;
        sample();
        check("mr md_start", 32'(md_start), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            sample();
        end
        check("mr busy hold", 32'(hold_dx), 1);
        #1;
        reset = 1'b1;
        md_ready = 1'b1;
        #1;
        check("mr async hold",      32'(hold_dx), 0);
        check("mr async stall",     32'(stall_fd), 0);
        check("mr async bubble_xm", 32'(bubble_xm), 0);
        check("mr async bubble_dx", 32'(bubble_dx), 0);
        check("mr async md_start",  32'(md_start), 0);
        check("mr async md_wb",     32'(md_wb), 0);
        check("mr async md_dest",   32'(md_dest), 0);
        tick();
        tick();
        reset = 1'b0;
        sample();
        check("mr release md_start", 32'(md_start), 1);
        check("mr release md_wb", 32'(md_wb), 0);
        tick();
        md_ready = 1'b0;
        sample();
        check("mr stale ready ignored", 32'(hold_dx), 1);
        check("mr stale md_wb", 32'(md_wb), 0);
        start_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            sample();
            if (md_start) start_cnt++;
        end
        check("mr single start", start_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
